fetch_stage_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage ARM pipeline, directly upstream of decode.
- Owns the program counter and drives it to the instruction memory as a byte address.
- Captures the returned 32-bit word, together with PC+4, into the IF/ID pipeline register.
- Handles freeze from the hazard unit, branch redirect and flush from EX, and keeps a retired-fetch counter.

---
 rtl/fetch_stage_unit.sv | 89 ++++++++
 tb/tb_fetch_stage_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_unit.sv
// Instruction-fetch stage: owns the PC, presents it to instruction memory as a
// byte address, and captures the returned word plus PC+4 into the IF/ID register.
// Handles hazard freeze, branch redirect/flush from EX, and a retired-fetch counter.
//
// Ports:
//   clk           pipeline clock, rising edge
//   rst           synchronous reset, active-low
//   freeze        hazard stall; holds PC and IF/ID
//   branch_taken  redirect request from EX; flushes IF/ID
//   branch_addr   redirect target byte address (low two bits ignored)
//   imem_instr    word returned combinationally for imem_pc
//   imem_pc       current PC (registered)
//   if_id_pc      PC+4 of captured instruction (registered)
//   if_id_instr   captured instruction word (registered)
//   if_id_valid   IF/ID holds a real instruction (registered)
//   out_of_range  combinational: imem_pc beyond last word of memory
//   fetch_count   saturating count of instructions advanced into IF/ID
module fetch_stage_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 192,
  parameter int unsigned COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [31:0]        branch_addr,
  input  logic [31:0]        imem_instr,
  output logic [31:0]        imem_pc,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_instr,
  output logic               if_id_valid,
  output logic               out_of_range,
  output logic [COUNT_W-1:0] fetch_count
);

  localparam int unsigned LAST_WORD = MEM_BYTES - 4;
  localparam logic [31:0] LAST_ADDR = 32'(LAST_WORD);

  logic [31:0]        r_pc;
  logic [31:0]        r_if_id_pc;
  logic [31:0]        r_if_id_instr;
  logic               r_if_id_valid;
  logic [COUNT_W-1:0] r_fetch_count;

  logic [31:0]        w_pc_plus4;
  logic [31:0]        w_branch_target;
  logic               w_count_sat;

  // Sequential fetch address wraps naturally at 2^32.
  assign w_pc_plus4      = r_pc + 32'd4;
  // Redirect targets are always word aligned.
  assign w_branch_target = branch_addr & ~32'd3;
  assign w_count_sat     = &r_fetch_count;

  // PC and IF/ID update: reset > branch > freeze > advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_if_id_pc    <= 32'd0;
      r_if_id_instr <= 32'd0;
      r_if_id_valid <= 1'b0;
      r_fetch_count <= '0;
    end else if (branch_taken) begin
      // Squash the wrong-path word currently being fetched.
      r_pc          <= w_branch_target;
      r_if_id_pc    <= 32'd0;
      r_if_id_instr <= 32'd0;
      r_if_id_valid <= 1'b0;
    end else if (!freeze) begin
      r_pc          <= w_pc_plus4;
      r_if_id_pc    <= w_pc_plus4;
      r_if_id_instr <= imem_instr;
      r_if_id_valid <= 1'b1;
      if (!w_count_sat) begin
        r_fetch_count <= r_fetch_count + COUNT_W'(1);
      end
    end
  end

  assign imem_pc      = r_pc;
  assign if_id_pc     = r_if_id_pc;
  assign if_id_instr  = r_if_id_instr;
  assign if_id_valid  = r_if_id_valid;
  assign fetch_count  = r_fetch_count;
  // Informational only; fetch continues regardless.
  assign out_of_range = (r_pc > LAST_ADDR);

endmodule

// File: tb/tb_fetch_stage_unit.sv
// Self-checking bench for fetch_stage_unit with a behavioural reference model.
module tb_fetch_stage_unit;

  localparam int unsigned CW        = 4;
  localparam int unsigned MEM_BYTES = 192;
  localparam int unsigned CNT_MAX   = 15;

  logic          clk;
  logic          rst;
  logic          freeze;
  logic          branch_taken;
  logic [31:0]   branch_addr;
  logic [31:0]   imem_instr;
  logic [31:0]   imem_pc;
  logic [31:0]   if_id_pc;
  logic [31:0]   if_id_instr;
  logic          if_id_valid;
  logic          out_of_range;
  logic [CW-1:0] fetch_count;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_stage_unit #(
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(MEM_BYTES),
    .COUNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem_instr  (imem_instr),
    .imem_pc     (imem_pc),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .out_of_range(out_of_range),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word n holds n+1.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr >> 2) + 32'd1;
  endfunction
  assign imem_instr = mem_word(imem_pc);

  // Reference model state.
  longint unsigned m_pc;
  longint unsigned m_ifpc;
  longint unsigned m_instr;
  bit              m_valid;
  int unsigned     m_cnt;
  bit              m_known = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_pc = 0; m_ifpc = 0; m_instr = 0; m_valid = 0; m_cnt = 0;
      m_known = 1'b1;
    end else if (branch_taken) begin
      m_pc    = longint'(branch_addr) - (longint'(branch_addr) % 4);
      m_ifpc  = 0; m_instr = 0; m_valid = 0;
    end else if (!freeze) begin
      m_instr = longint'(mem_word(32'(m_pc)));
      m_pc    = (m_pc + 4) % (64'd1 << 32);
      m_ifpc  = m_pc;
      m_valid = 1;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      chk("model imem_pc",      longint'(imem_pc),      m_pc);
      chk("model if_id_pc",     longint'(if_id_pc),     m_ifpc);
      chk("model if_id_instr",  longint'(if_id_instr),  m_instr);
      chk("model if_id_valid",  longint'(if_id_valid),  longint'(m_valid));
      chk("model fetch_count",  longint'(fetch_count),  longint'(m_cnt));
      chk("model out_of_range", longint'(out_of_range), longint'(m_pc > MEM_BYTES - 4));
    end
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;

    // Reset then run.
    edges(2);
    chk("reset pc",    imem_pc, 0);
    chk("reset valid", if_id_valid, 0);
    chk("reset count", fetch_count, 0);
    rst = 1'b1;
    edges(1); chk("run pc1", imem_pc, 4);
    edges(1); chk("run pc2", imem_pc, 8);
    edges(1); chk("run pc3", imem_pc, 12);
    chk("run if_id_pc", if_id_pc, 12);
    chk("run instr",    if_id_instr, 3);
    chk("run valid",    if_id_valid, 1);
    chk("run count",    fetch_count, 3);

    // Freeze at imem_pc=8.
    rst = 1'b0; edges(1); rst = 1'b1;
    edges(2);
    chk("pre-freeze pc", imem_pc, 8);
    freeze = 1'b1;
    edges(3);
    chk("freeze pc",       imem_pc, 8);
    chk("freeze if_id_pc", if_id_pc, 8);
    chk("freeze count",    fetch_count, 2);
    freeze = 1'b0;
    edges(1);
    chk("release if_id_pc", if_id_pc, 12);
    chk("release instr",    if_id_instr, 3);
    edges(1);
    chk("pre-branch pc", imem_pc, 16);

    // Branch with freeze: target low bits forced to zero.
    branch_taken = 1'b1; freeze = 1'b1; branch_addr = 32'h0000_0046;
    edges(1);
    chk("branch pc",    imem_pc, 32'h44);
    chk("branch valid", if_id_valid, 0);
    chk("branch instr", if_id_instr, 0);
    chk("branch count", fetch_count, 4);
    branch_taken = 1'b0; freeze = 1'b0;
    edges(1);
    chk("target if_id_pc", if_id_pc, 32'h48);
    chk("target instr",    if_id_instr, 18);
    chk("target count",    fetch_count, 5);

    // Reset mid-operation while frozen.
    edges(3);
    freeze = 1'b1;
    edges(1);
    rst = 1'b0;
    edges(1);
    chk("midreset pc",    imem_pc, 0);
    chk("midreset valid", if_id_valid, 0);
    chk("midreset count", fetch_count, 0);
    // Reset also overrides a branch.
    branch_taken = 1'b1; branch_addr = 32'h100;
    edges(1);
    chk("reset over branch pc", imem_pc, 0);
    rst = 1'b1; freeze = 1'b0;

    // Back-to-back branches.
    branch_addr = 32'h10; edges(1);
    branch_addr = 32'h20; edges(1);
    chk("b2b pc",    imem_pc, 32'h20);
    chk("b2b valid", if_id_valid, 0);

    // Range and wrap.
    branch_addr = 32'd188; edges(1);
    chk("range 188 pc",  imem_pc, 188);
    chk("range 188 oor", out_of_range, 0);
    branch_taken = 1'b0; edges(1);
    chk("range 192 pc",    imem_pc, 192);
    chk("range 192 oor",   out_of_range, 1);
    chk("range 188 instr", if_id_instr, 48);
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFF; edges(1);
    chk("wrap branch pc", imem_pc, 32'hFFFF_FFFC);
    branch_taken = 1'b0; edges(1);
    chk("wrap pc",       imem_pc, 0);
    chk("wrap if_id_pc", if_id_pc, 0);
    chk("wrap oor",      out_of_range, 0);
    chk("wrap count",    fetch_count, 2);

    // Counter saturation.
    edges(20);
    chk("sat count", fetch_count, 15);
    freeze = 1'b1; edges(2); freeze = 1'b0;
    edges(3);
    chk("sat hold", fetch_count, 15);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
